// File: rtl/uart_msg_pkg.sv
// Shared types, ASCII constants and hex decoding for the UART message loader.
package uart_msg_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_9  = 8'h39;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_F  = 8'h46;
  localparam logic [7:0] ASC_a  = 8'h61;
  localparam logic [7:0] ASC_f  = 8'h66;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  typedef struct packed {
    logic       legal;
    logic [3:0] nibble;
  } hex_t;

  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t r;
    r = '0;
    if (c >= ASC_0 && c <= ASC_9) begin
      r.legal  = 1'b1;
      r.nibble = 4'(c - ASC_0);
    end else if (c >= ASC_A && c <= ASC_F) begin
      r.legal  = 1'b1;
      r.nibble = 4'(c - ASC_A + 8'd10);
    end else if (c >= ASC_a && c <= ASC_f) begin
      r.legal  = 1'b1;
      r.nibble = 4'(c - ASC_a + 8'd10);
    end
    return r;
  endfunction

  function automatic logic is_line_break(input logic [7:0] c);
    return (c == ASC_CR) || (c == ASC_LF);
  endfunction

endpackage

// File: rtl/uart_msg_if.sv
// Serial input and published-message outputs of the UART message loader.
interface uart_msg_if #(
  parameter int MSG_CHARS = 16
);
  logic                   rx;
  logic [4*MSG_CHARS-1:0] message;
  logic                   msg_valid;
  logic                   char_err;
  logic                   busy;

  modport master (input rx, output message, msg_valid, char_err, busy);
  modport slave  (output rx, input message, msg_valid, char_err, busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchronizer, mid-bit sampling FSM, one-cycle byte/error strobes.
module uart_rx_byte
  import uart_msg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_ok,
  output logic       frame_err,
  output logic       busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state;
  logic          rx_meta, rx_s;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;

  assign data = shift_q;

  // NOTE: every register here is assigned with <= so all flops update from
  // the same pre-edge values; a blocking = would let later lines see new state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            timer <= '0;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          // Re-check the line at mid start bit so short glitches are dropped.
          if (timer == HALF_LAST) begin
            timer <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == BIT_LAST) begin
            timer   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_cnt == 3'd7) state <= STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_s) byte_ok   <= 1'b1;
            else      frame_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_message_loader.sv
// Decodes received hex characters and publishes each complete message atomically.
module uart_message_loader
  import uart_msg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MSG_CHARS    = 16
) (
  input logic        clk,
  input logic        reset,
  uart_msg_if.master bus
);
  localparam int MW = 4 * MSG_CHARS;
  localparam int IW = (MSG_CHARS > 1) ? $clog2(MSG_CHARS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_CHARS - 1);

  logic [7:0]    rx_data;
  logic          byte_ok, frame_err;
  logic [IW-1:0] idx;
  logic [MW-1:0] shadow, shadow_next, message_q;
  logic          msg_valid_q, char_err_q;
  hex_t          hex;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (bus.rx),
    .data      (rx_data),
    .byte_ok   (byte_ok),
    .frame_err (frame_err),
    .busy      (bus.busy)
  );

  assign bus.message   = message_q;
  assign bus.msg_valid = msg_valid_q;
  assign bus.char_err  = char_err_q;

  // NOTE: shadow_next gets a full default before the partial overwrite, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hex         = hex_decode(rx_data);
    shadow_next = shadow;
    shadow_next[4*(MSG_CHARS-1-int'(idx)) +: 4] = hex.nibble;
  end

  // NOTE: shadow is a flop bank, not a RAM, so clearing it in reset costs nothing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx         <= '0;
      shadow      <= '0;
      message_q   <= '0;
      msg_valid_q <= 1'b0;
      char_err_q  <= 1'b0;
    end else begin
      msg_valid_q <= 1'b0;
      char_err_q  <= 1'b0;
      if (frame_err) begin
        char_err_q <= 1'b1;
        idx        <= '0;
      end else if (byte_ok) begin
        if (hex.legal) begin
          shadow <= shadow_next;
          // The last nibble goes straight into message so it is never partial.
          if (idx == LAST_IDX) begin
            message_q   <= shadow_next;
            msg_valid_q <= 1'b1;
            idx         <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end else if (is_line_break(rx_data)) begin
          idx <= '0;
        end else begin
          char_err_q <= 1'b1;
          idx        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_message_loader.sv
// Bench for uart_message_loader: string-level reference model plus per-cycle output compare.
module tb_uart_message_loader;
  localparam int CPB    = 16;
  localparam int FRAME  = 10 * CPB;
  localparam int BZ_OFF = 3;                          // two sync flops + idle detect
  localparam int BZ_END = BZ_OFF + CPB/2 + 9*CPB;     // stop-bit sample
  localparam int LAT    = BZ_END + 1;                 // decode register

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_msg_if #(.MSG_CHARS(16)) bus ();

  uart_message_loader #(.CLKS_PER_BIT(CPB), .MSG_CHARS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    bit          valid;
    bit          err;
    logic [63:0] msg;
  } ev_t;

  ev_t         evq[$];
  string       line = "";
  logic [63:0] exp_message = '0;
  int bz_from = 0, bz_to = 0, skip_until = 0;
  int n_valid = 0, n_err = 0, n_busy = 0, last_valid_cyc = 0, last_start = 0;

  function automatic int hex_val(input byte c);
    string digits;
    digits = "0123456789abcdefABCDEF";
    for (int i = 0; i < digits.len(); i++)
      if (digits[i] == c) return (i < 16) ? i : i - 6;
    return -1;
  endfunction

  function automatic logic [63:0] line_value(input string s);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v = (v << 4) | 64'(hex_val(s[i]));
    return v;
  endfunction

  // Reference: accumulate legal characters as text; 16 of them form a message.
  task automatic model_char(input byte c, input bit stop_ok);
    ev_t e;
    e.due = cyc + LAT; e.valid = 1'b0; e.err = 1'b0; e.msg = '0;
    if (!stop_ok) begin
      e.err = 1'b1; line = "";
    end else if (hex_val(c) >= 0) begin
      line = {line, $sformatf("%c", c)};
      if (line.len() == 16) begin
        e.valid = 1'b1; e.msg = line_value(line); line = "";
      end
    end else if (c == 8'h0D || c == 8'h0A) begin
      line = "";
    end else begin
      e.err = 1'b1; line = "";
    end
    evq.push_back(e);
  endtask

  task automatic send_frame(input byte c, input bit stop_ok, input int rst_at);
    last_start = cyc;
    model_char(c, stop_ok);
    bz_from = cyc + BZ_OFF;
    bz_to   = cyc + BZ_END;
    if (!stop_ok) skip_until = cyc + FRAME + CPB;
    for (int i = 0; i < FRAME; i++) begin
      int k;
      k = i / CPB;
      bus.rx = (k == 0) ? 1'b0 : (k <= 8) ? c[k-1] : stop_ok;
      reset  = (i == rst_at) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, -1);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic glitch();
    bz_from = cyc + BZ_OFF;
    bz_to   = cyc + BZ_OFF + CPB/2;
    bus.rx = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    idle(2 * CPB);
  endtask

  initial begin
    forever begin
      bit exp_v, exp_e;
      @(negedge clk);
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (!rst_q) begin
        evq.delete();
        line = "";
        exp_message = '0;
        bz_from = 0;
        bz_to   = 0;
      end else if (evq.size() > 0 && evq[0].due == cyc) begin
        exp_v = evq[0].valid;
        exp_e = evq[0].err;
        if (exp_v) exp_message = evq[0].msg;
        void'(evq.pop_front());
      end
      check("msg_valid", 64'(bus.msg_valid), 64'(exp_v));
      check("char_err",  64'(bus.char_err),  64'(exp_e));
      check("message",   bus.message, exp_message);
      if (cyc >= skip_until)
        check("busy", 64'(bus.busy), 64'(cyc >= bz_from && cyc < bz_to));
      if (bus.msg_valid) begin n_valid++; last_valid_cyc = cyc; end
      if (bus.char_err) n_err++;
      if (bus.busy) n_busy++;
    end
  end

  initial begin
    int v0, e0, b0;
    bus.rx = 1'b1;
    reset  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rx = i[0];
      @(posedge clk); #1;
    end
    check("reset_message", bus.message, 64'h0);
    check("reset_busy", 64'(bus.busy), 64'h0);
    bus.rx = 1'b1;
    reset  = 1'b1;
    idle(4);

    v0 = n_valid; e0 = n_err;
    send_str("0123456789ABCDEF");
    idle(4);
    check("full_valid_count", 64'(n_valid - v0), 64'd1);
    check("full_err_count", 64'(n_err - e0), 64'd0);
    check("full_message", bus.message, 64'h0123456789ABCDEF);
    check("full_latency", 64'(last_valid_cyc - last_start), 64'd156);

    v0 = n_valid;
    send_str("0123456789ABCDEF");
    check("first_message", bus.message, 64'h0123456789ABCDEF);
    send_str("fedcba9876543210");
    idle(4);
    check("lower_valid_count", 64'(n_valid - v0), 64'd2);
    check("lower_message", bus.message, 64'hFEDCBA9876543210);

    v0 = n_valid; e0 = n_err;
    send_str("12G");
    send_str("7777777777777777");
    idle(4);
    check("illegal_err_count", 64'(n_err - e0), 64'd1);
    check("illegal_valid_count", 64'(n_valid - v0), 64'd1);
    check("illegal_message", bus.message, 64'h7777777777777777);

    v0 = n_valid; e0 = n_err;
    send_str("12");
    send_frame(8'h0D, 1'b1, -1);
    send_str("7777777777777777");
    idle(4);
    check("cr_err_count", 64'(n_err - e0), 64'd0);
    check("cr_valid_count", 64'(n_valid - v0), 64'd1);

    v0 = n_valid; e0 = n_err;
    send_str("0123");
    send_frame(8'h34, 1'b0, -1);
    idle(2 * CPB);
    send_str("89ABCDEF01234567");
    idle(4);
    check("frame_err_count", 64'(n_err - e0), 64'd1);
    check("frame_valid_count", 64'(n_valid - v0), 64'd1);
    check("frame_message", bus.message, 64'h89ABCDEF01234567);

    v0 = n_valid; e0 = n_err; b0 = n_busy;
    glitch();
    check("glitch_err_count", 64'(n_err - e0), 64'd0);
    check("glitch_valid_count", 64'(n_valid - v0), 64'd0);
    check("glitch_busy_cycles", 64'(n_busy - b0), 64'd8);
    check("glitch_busy_end", 64'(bus.busy), 64'd0);

    send_str("0123456789");
    send_frame(8'h41, 1'b1, 146);
    idle(8);
    check("midreset_message", bus.message, 64'h0);
    v0 = n_valid;
    send_str("AAAAAAAAAAAAAAAA");
    idle(4);
    check("midreset_valid_count", 64'(n_valid - v0), 64'd1);
    check("midreset_message_after", bus.message, 64'hAAAAAAAAAAAAAAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_message_loader.md
Name: uart_message_loader

Overview:
- Upstream feeder for the 64-bit `message` bus consumed by Message_init, the Text_scroll path and the four-digit LED driver.
- Receives 8N1 serial ASCII on a single RX pin and decodes hex characters into 4-bit codes.
- Assembles 16 codes into a full 64-bit message and publishes it atomically, with a one-cycle valid strobe.
- Runs on the undivided board clock `clk`, not `clk_new`.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- MSG_CHARS, 16, characters per message; message width = 4*MSG_CHARS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- rx  in  1  asynchronous UART line, idle high.
- message  out  64  last complete message; char 0 in [63:60], char 15 in [3:0].
- msg_valid  out  1  one-cycle pulse when `message` updates.
- char_err  out  1  one-cycle pulse on framing error or illegal byte.
- busy  out  1  high while a frame is being received (FSM not IDLE).

Behaviour:
- **Reset values** (reset==0 at a clk edge):
  - message=64'h0, msg_valid=0, char_err=0, busy=0.
  - Character index=0, shadow register=0, FSM=IDLE.
  - Synchronizer flops=1.
  - Reset mid-frame discards the partial byte and partial message.
- **RX synchronizer:** two flops on rx → rx_s. All decisions use rx_s only.
- **FSM IDLE:** when rx_s==0, clear the bit timer and go to START.
- **FSM START:**
  - Count to CLKS_PER_BIT/2 - 1 (integer division).
  - If rx_s==0, go to DATA with bit counter 0.
  - If rx_s==1, the start was a glitch: return to IDLE, no error.
- **FSM DATA:**
  - Every CLKS_PER_BIT cycles, sample rx_s into shift reg, LSB first.
  - After bit 7 is sampled, go to STOP.
- **FSM STOP:**
  - After CLKS_PER_BIT cycles, sample rx_s and go to IDLE.
  - rx_s==1: byte is good and is handed to decode the next cycle.
  - rx_s==0: framing error. char_err pulses the next cycle, index←0, shadow unchanged.
- **Byte decode**, registered, one cycle after the stop sample:
  - '0'–'9' (0x30–0x39) → 0–9.
  - 'A'–'F' (0x41–0x46) and 'a'–'f' (0x61–0x66) → 10–15.
  - CR (0x0D) or LF (0x0A): index←0, partial message discarded, no error, no valid.
  - Any other byte: char_err pulse, index←0.
- **Assembly:**
  - Each good nibble is written into shadow[4*(MSG_CHARS-1-index) +: 4], then index++.
  - When the nibble at index MSG_CHARS-1 is accepted, in that same cycle:
    - message ← shadow with the final nibble merged;
    - msg_valid=1;
    - index←0.
  - Shadow is not cleared between messages; every position is overwritten before the next publish.
- **Output timing:**
  - `message` changes only on msg_valid cycles; it never shows a partial message.
  - msg_valid and char_err are never both high.
- **Latency:** stop-bit sample at cycle S; msg_valid/char_err at S+1.
- **Back-to-back frames:** a new start bit may be detected the cycle after STOP. Decode of the previous byte overlaps the new START without loss.

Decomposition:
- Package uart_msg_pkg:
  - FSM state enum (IDLE, START, DATA, STOP);
  - ASCII constants (ASC_0, ASC_9, ASC_A, ASC_F, ASC_a, ASC_f, ASC_CR, ASC_LF);
  - hex-decode function returning {legal, nibble}.
- Sub-module uart_rx_byte:
  - contains the synchronizer, FSM, bit/baud counters;
  - outputs byte[7:0], byte_ok pulse, frame_err pulse, busy.
- Top level holds the decode, index counter, shadow and message registers.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
- **Reset:** hold reset=0 for 3 clks with rx toggling → message=0, msg_valid=0, char_err=0, busy=0 throughout.
- **Full message:** send "0123456789ABCDEF" back-to-back → exactly one msg_valid pulse, one cycle after the 16th stop-bit sample; message=64'h0123456789ABCDEF; char_err never asserted.
- **Lower case plus prior message:** send "0123456789ABCDEF" then "fedcba9876543210" → first msg_valid gives message=64'h0123456789ABCDEF; second msg_valid gives message=64'hFEDCBA9876543210; message unchanged between the two pulses.
- **Illegal byte / line break:**
  - Send "12G" then 16 × "7" → char_err pulses once at 'G'; message=64'h7777777777777777 with no earlier valid.
  - Repeat with CR in place of 'G' → no char_err.
- **Framing error and glitch:**
  - Drive stop bit low on the 5th char → char_err pulse; the following 16 good chars publish correctly.
  - A 3-cycle low glitch on idle rx → busy returns to 0, no error, no byte.
- **Reset mid-message:** send 10 chars, pulse reset=0 for 1 clk during the 11th frame, then send 16 chars "AAAAAAAAAAAAAAAA" → single msg_valid with message=64'hAAAAAAAAAAAAAAAA.
